// File: rtl/npu_pkg.sv
`default_nettype none
//==============================================================================
// Module   : npu_pkg
// Brief    : Shared definitions for the layer-parameter fetch path: FSM state
//            encoding, descriptor layout, descriptor stride and flag bit order.
// Revision : 1.0 - initial release
//==============================================================================
package npu_pkg;

    // Fetch FSM state encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_cmd  = 2'd1;
    localparam logic [1:0] c_st_data = 2'd2;
    localparam logic [1:0] c_st_resp = 2'd3;

    // Descriptor size in 64-bit words and byte stride between descriptors (1 << 5 = 32)
    localparam int c_para_words = 4;
    localparam int c_para_shift = 5;

    // Beat 0 field positions
    localparam int c_in_ch_lsb  = 0;
    localparam int c_out_ch_lsb = 16;
    localparam int c_map_h_lsb  = 32;
    localparam int c_map_w_lsb  = 48;

    // Beat 1 field positions
    localparam int c_kernel_lsb = 0;
    localparam int c_stride_lsb = 4;
    localparam int c_pad_lsb    = 8;
    localparam int c_flags_lsb  = 12;
    localparam int c_wt_off_lsb = 32;

    // Beat 2 field positions (upper word reserved)
    localparam int c_bn_off_lsb = 0;

    // Flag bit order inside the 4-bit flags field: {bn_en, map_sel, pool, relu}
    localparam int c_flag_relu    = 0;
    localparam int c_flag_pool    = 1;
    localparam int c_flag_map_sel = 2;
    localparam int c_flag_bn_en   = 3;

    // Decoded descriptor
    typedef struct packed {
        logic [15:0] in_ch;
        logic [15:0] out_ch;
        logic [15:0] map_h;
        logic [15:0] map_w;
        logic [3:0]  kernel;
        logic [3:0]  stride;
        logic [3:0]  pad;
        logic [3:0]  flags;
        logic [31:0] wt_off;
        logic [31:0] bn_off;
    } npu_para_t;

endpackage
`default_nettype wire

// File: rtl/npu_para_unpack.sv
`default_nettype none
//==============================================================================
// Module   : npu_para_unpack
// Brief    : Registered per-beat extraction of descriptor fields. When
//            NPU_PARA_CSUM_EN is defined it also keeps a running XOR of beats
//            0..2 and compares it against beat 3.
// Revision : 1.0 - initial release
//==============================================================================
module npu_para_unpack
    import npu_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,         // start of a new transaction
    input  logic          beat_valid,  // accepted beat while fetching
    input  logic [1:0]    beat_idx,
    input  logic [DW-1:0] beat_data,
    output npu_para_t     para,
    output logic          csum_bad
);

    npu_para_t r_para;

    // Capture the fields carried by each beat; cleared at every new request
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_para <= '0;
        end else if (beat_valid) begin
            case (beat_idx)
                2'd0: begin
                    r_para.in_ch  <= beat_data[c_in_ch_lsb  +: 16];
                    r_para.out_ch <= beat_data[c_out_ch_lsb +: 16];
                    r_para.map_h  <= beat_data[c_map_h_lsb  +: 16];
                    r_para.map_w  <= beat_data[c_map_w_lsb  +: 16];
                end
                2'd1: begin
                    r_para.kernel <= beat_data[c_kernel_lsb +: 4];
                    r_para.stride <= beat_data[c_stride_lsb +: 4];
                    r_para.pad    <= beat_data[c_pad_lsb    +: 4];
                    r_para.flags[c_flag_relu]    <= beat_data[c_flags_lsb + c_flag_relu];
                    r_para.flags[c_flag_pool]    <= beat_data[c_flags_lsb + c_flag_pool];
                    r_para.flags[c_flag_map_sel] <= beat_data[c_flags_lsb + c_flag_map_sel];
                    r_para.flags[c_flag_bn_en]   <= beat_data[c_flags_lsb + c_flag_bn_en];
                    r_para.wt_off <= beat_data[c_wt_off_lsb +: 32];
                end
                2'd2: begin
                    r_para.bn_off <= beat_data[c_bn_off_lsb +: 32];
                end
                default: begin
                    // checksum word carries no fields
                end
            endcase
        end
    end

    assign para = r_para;

`ifdef NPU_PARA_CSUM_EN
    logic [DW-1:0] r_xor;
    logic          r_csum_bad;

    // Accumulate beats 0..2, then compare against the checksum word in beat 3
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_xor      <= '0;
            r_csum_bad <= 1'b0;
        end else if (beat_valid) begin
            if (beat_idx == 2'd3) begin
                r_csum_bad <= (beat_data != r_xor);
            end else begin
                r_xor <= r_xor ^ beat_data;
            end
        end
    end

    assign csum_bad = r_csum_bad;
`else
    assign csum_bad = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/npu_layer_para_fetch.sv
`default_nettype none
//==============================================================================
// Module   : npu_layer_para_fetch
// Brief    : Services MCU layer-parameter requests: range-checks the index,
//            issues a 4-beat DDR read of the layer descriptor and returns the
//            decoded fields in a single response beat.
//            Optional checksum verification: NPU_PARA_CSUM_EN.
// Revision : 1.0 - initial release
//==============================================================================
module npu_layer_para_fetch
    import npu_pkg::*;
#(
    parameter int DW         = 64,
    parameter int PARA_WORDS = c_para_words,
    parameter int DDR_AW     = 32
) (
    input  logic              clk_trans,
    input  logic              rst,
    input  logic [DDR_AW-1:0] nn_layer_para_saddr,
    input  logic [7:0]        nn_layers_num,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [7:0]        req_layer_idx,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_err,
    output logic [15:0]       resp_in_ch,
    output logic [15:0]       resp_out_ch,
    output logic [15:0]       resp_map_h,
    output logic [15:0]       resp_map_w,
    output logic [3:0]        resp_kernel,
    output logic [3:0]        resp_stride,
    output logic [3:0]        resp_pad,
    output logic [3:0]        resp_flags,
    output logic [31:0]       resp_wt_off,
    output logic [31:0]       resp_bn_off,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [DDR_AW-1:0] rd_addr,
    output logic [7:0]        rd_len,
    input  logic              rd_data_valid,
    input  logic              rd_data_last,
    input  logic [DW-1:0]     rd_data
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [1:0]        r_beat_cnt;
    logic [DDR_AW-1:0] r_rd_addr;
    logic [7:0]        r_rd_len;
    logic              r_err;

    logic              w_req_acc;
    logic              w_idx_bad;
    logic              w_beat_acc;
    logic              w_beat_final;
    logic              w_csum_bad;
    npu_para_t         w_para;

    assign w_req_acc    = (r_state == c_st_idle) && req_valid;
    assign w_idx_bad    = (req_layer_idx >= nn_layers_num);
    assign w_beat_acc   = (r_state == c_st_data) && rd_data_valid;
    assign w_beat_final = (r_beat_cnt == 2'(PARA_WORDS - 1));

    // State register
    always_ff @(posedge clk_trans) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a short burst ends the fetch as soon as last is seen
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (req_valid) begin
                    w_state_nxt = w_idx_bad ? c_st_resp : c_st_cmd;
                end
            end
            c_st_cmd: begin
                if (rd_req_ready) begin
                    w_state_nxt = c_st_data;
                end
            end
            c_st_data: begin
                if (w_beat_acc && (w_beat_final || rd_data_last)) begin
                    w_state_nxt = c_st_resp;
                end
            end
            default: begin
                if (resp_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
        endcase
    end

    // Handshake outputs decoded from the registered state
    always_comb begin
        req_ready    = (r_state == c_st_idle);
        rd_req_valid = (r_state == c_st_cmd);
        resp_valid   = (r_state == c_st_resp);
    end

    // Transaction datapath: command address, beat counter and error flag
    always_ff @(posedge clk_trans) begin
        if (rst) begin
            r_rd_addr  <= '0;
            r_rd_len   <= 8'd0;
            r_beat_cnt <= 2'd0;
            r_err      <= 1'b0;
        end else begin
            r_rd_len <= 8'(PARA_WORDS - 1);
            if (w_req_acc) begin
                r_rd_addr  <= nn_layer_para_saddr + (DDR_AW'(req_layer_idx) << c_para_shift);
                r_beat_cnt <= 2'd0;
                r_err      <= w_idx_bad;
            end else if (w_beat_acc) begin
                r_beat_cnt <= r_beat_cnt + 2'd1;
                if (rd_data_last && !w_beat_final) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    npu_para_unpack #(
        .DW (DW)
    ) u_unpack (
        .clk        (clk_trans),
        .rst        (rst),
        .clr        (w_req_acc),
        .beat_valid (w_beat_acc),
        .beat_idx   (r_beat_cnt),
        .beat_data  (rd_data),
        .para       (w_para),
        .csum_bad   (w_csum_bad)
    );

    assign rd_addr     = r_rd_addr;
    assign rd_len      = r_rd_len;
    assign resp_err    = r_err | w_csum_bad;
    assign resp_in_ch  = w_para.in_ch;
    assign resp_out_ch = w_para.out_ch;
    assign resp_map_h  = w_para.map_h;
    assign resp_map_w  = w_para.map_w;
    assign resp_kernel = w_para.kernel;
    assign resp_stride = w_para.stride;
    assign resp_pad    = w_para.pad;
    assign resp_flags  = w_para.flags;
    assign resp_wt_off = w_para.wt_off;
    assign resp_bn_off = w_para.bn_off;

endmodule
`default_nettype wire
